// File: rtl/el2_pkg.sv
// Shared EL2 trace types: retire-trace packet layout and trace-buffer overflow policy.
package el2_pkg;

  typedef struct packed {
    logic        trace_rv_i_valid_ip;
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_pkt_t;

  typedef enum logic {
    TRC_DROP  = 1'b0,
    TRC_STALL = 1'b1
  } el2_trace_ovf_mode_t;

  localparam int unsigned TRACE_PKT_W = $bits(el2_trace_pkt_t);

endpackage

// File: rtl/el2_trace_buf_if.sv
// Trace buffer stream bundle: NCH retire lanes in, one packet per cycle out to the sink.
interface el2_trace_buf_if #(
  parameter int unsigned NCH = 2
);
  import el2_pkg::*;

  el2_trace_pkt_t [NCH-1:0] trace_in_pkt;
  logic                     trace_stall;
  logic                     trace_out_valid;
  el2_trace_pkt_t           trace_out_pkt;
  logic                     trace_out_ready;

  modport master (
    output trace_in_pkt,
    output trace_out_ready,
    input  trace_stall,
    input  trace_out_valid,
    input  trace_out_pkt
  );

  modport slave (
    input  trace_in_pkt,
    input  trace_out_ready,
    output trace_stall,
    output trace_out_valid,
    output trace_out_pkt
  );

endinterface

// File: rtl/el2_trace_lane_pack.sv
// Lane compaction: each valid lane gets a dense write-slot offset (prefix count of valid lanes below it).
module el2_trace_lane_pack #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned OFF_W = $clog2(NCH + 1)
) (
  input  logic [NCH-1:0]            lane_valid,
  output logic [NCH-1:0][OFF_W-1:0] lane_off,
  output logic [OFF_W-1:0]          nvalid
);

  logic [OFF_W-1:0] run;

  always_comb begin
    run      = '0;
    lane_off = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      lane_off[i] = run;
      run         = run + OFF_W'(lane_valid[i]);
    end
    nvalid = run;
  end

endmodule

// File: rtl/el2_trace_buf.sv
// Multi-lane retire-trace buffer: compacts up to NCH packets per cycle into a circular FIFO,
// drains one per cycle, and drops or stalls on overflow with saturating drop accounting.
module el2_trace_buf
  import el2_pkg::*;
#(
  parameter int unsigned         DEPTH    = 8,
  parameter int unsigned         NCH      = 2,
  parameter el2_trace_ovf_mode_t OVF_MODE = TRC_DROP,
  parameter int unsigned         CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       trace_en,
  el2_trace_buf_if.slave             trc,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       drop_flag,
  input  logic                       drop_clr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned OFF_W = $clog2(NCH + 1);
  localparam int unsigned SUM_W = ((CNT_W > LVL_W) ? CNT_W : LVL_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  el2_trace_pkt_t mem [DEPTH];

  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [NCH-1:0]              lane_valid;
  logic [NCH-1:0][OFF_W-1:0]   lane_off;
  logic [OFF_W-1:0]            nvalid;
  logic                        pop;
  logic [LVL_W-1:0]            avail;
  logic [LVL_W-1:0]            accepted;
  logic [LVL_W-1:0]            dropped;
  logic [LVL_W-1:0]            level_next;
  logic [SUM_W-1:0]            cnt_sum;
  logic [CNT_W-1:0]            cnt_next;
  logic                        flag_next;
  logic                        stall_q;

  always_comb begin
    lane_valid = '0;
    for (int unsigned i = 0; i < NCH; i++)
      lane_valid[i] = trace_en & trc.trace_in_pkt[i].trace_rv_i_valid_ip;
  end

  el2_trace_lane_pack #(
    .NCH   (NCH),
    .OFF_W (OFF_W)
  ) u_lane_pack (
    .lane_valid (lane_valid),
    .lane_off   (lane_off),
    .nvalid     (nvalid)
  );

  // Output is gated to zero when empty so stale storage never reaches the sink.
  assign trc.trace_out_valid = (level != '0);
  assign trc.trace_out_pkt   = trc.trace_out_valid ? mem[rd_ptr] : '0;
  assign trc.trace_stall     = stall_q;
  assign pop                 = trc.trace_out_valid & trc.trace_out_ready;

  always_comb begin
    avail      = LVL_W'(DEPTH) - level + LVL_W'(pop);
    accepted   = (LVL_W'(nvalid) > avail) ? avail : LVL_W'(nvalid);
    dropped    = LVL_W'(nvalid) - accepted;
    level_next = level + accepted - LVL_W'(pop);
    cnt_sum    = SUM_W'(drop_clr ? '0 : drop_cnt) + SUM_W'(dropped);
    cnt_next   = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    flag_next  = (drop_flag & ~drop_clr) | (dropped != '0);
  end

  // Lanes beyond the accepted count are the ones dropped; offsets are distinct so writes never collide.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (lane_valid[i] && (LVL_W'(lane_off[i]) < accepted))
        mem[wr_ptr + PTR_W'(lane_off[i])] <= trc.trace_in_pkt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      drop_cnt  <= '0;
      drop_flag <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PTR_W'(accepted);
      rd_ptr    <= rd_ptr + PTR_W'(pop);
      level     <= level_next;
      drop_cnt  <= cnt_next;
      drop_flag <= flag_next;
      stall_q   <= (OVF_MODE == TRC_STALL) &&
                   ((LVL_W'(DEPTH) - level_next) < LVL_W'(NCH));
    end
  end

endmodule

// File: tb/tb_el2_trace_buf.sv
// Randomized and directed bench for el2_trace_buf; three configurations checked against a queue model.
module tb_el2_trace_buf;
  import el2_pkg::*;

  typedef struct packed {
    logic           valid;
    el2_trace_pkt_t pkt;
    logic [7:0]     level;
    logic [15:0]    cnt;
    logic           flag;
    logic           stall;
  } obs_t;

  localparam int DEP  [3] = '{8, 8, 4};
  localparam int NCHS [3] = '{2, 4, 2};
  localparam int STM  [3] = '{0, 0, 1};
  localparam int CMX  [3] = '{65535, 15, 65535};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_a, en_b, en_c;
  logic        clr_a, clr_b, clr_c;
  logic [3:0]  lvl_a, lvl_b;
  logic [2:0]  lvl_c;
  logic [15:0] cnt_a, cnt_c;
  logic [3:0]  cnt_b;
  logic        flag_a, flag_b, flag_c;

  el2_trace_buf_if #(.NCH(2)) if_a ();
  el2_trace_buf_if #(.NCH(4)) if_b ();
  el2_trace_buf_if #(.NCH(2)) if_c ();

  el2_trace_buf #(.DEPTH(8), .NCH(2), .OVF_MODE(TRC_DROP), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .trace_en(en_a), .trc(if_a.slave),
    .level(lvl_a), .drop_cnt(cnt_a), .drop_flag(flag_a), .drop_clr(clr_a));

  el2_trace_buf #(.DEPTH(8), .NCH(4), .OVF_MODE(TRC_DROP), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .trace_en(en_b), .trc(if_b.slave),
    .level(lvl_b), .drop_cnt(cnt_b), .drop_flag(flag_b), .drop_clr(clr_b));

  el2_trace_buf #(.DEPTH(4), .NCH(2), .OVF_MODE(TRC_STALL), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .trace_en(en_c), .trc(if_c.slave),
    .level(lvl_c), .drop_cnt(cnt_c), .drop_flag(flag_c), .drop_clr(clr_c));

  int n_cmp = 0;
  int n_bad = 0;

  el2_trace_pkt_t mq [3][$];
  int unsigned    mcnt [3];
  bit             mflag [3];
  bit             mstall [3];

  function automatic el2_trace_pkt_t mk(bit v, logic [31:0] addr);
    el2_trace_pkt_t p;
    p.trace_rv_i_valid_ip     = v;
    p.trace_rv_i_insn_ip      = $urandom;
    p.trace_rv_i_address_ip   = addr;
    p.trace_rv_i_exception_ip = 1'($urandom);
    p.trace_rv_i_ecause_ip    = 5'($urandom);
    p.trace_rv_i_interrupt_ip = 1'($urandom);
    p.trace_rv_i_tval_ip      = $urandom;
    return p;
  endfunction

  function automatic obs_t obs_of(int id);
    obs_t o;
    o = '0;
    case (id)
      0: begin o.valid = if_a.trace_out_valid; o.pkt = if_a.trace_out_pkt; o.level = 8'(lvl_a);
               o.cnt = cnt_a; o.flag = flag_a; o.stall = if_a.trace_stall; end
      1: begin o.valid = if_b.trace_out_valid; o.pkt = if_b.trace_out_pkt; o.level = 8'(lvl_b);
               o.cnt = 16'(cnt_b); o.flag = flag_b; o.stall = if_b.trace_stall; end
      default: begin o.valid = if_c.trace_out_valid; o.pkt = if_c.trace_out_pkt; o.level = 8'(lvl_c);
               o.cnt = cnt_c; o.flag = flag_c; o.stall = if_c.trace_stall; end
    endcase
    return o;
  endfunction

  function automatic obs_t exp_obs(int id);
    obs_t o;
    o       = '0;
    o.valid = (mq[id].size() != 0);
    o.pkt   = o.valid ? mq[id][0] : '0;
    o.level = 8'(mq[id].size());
    o.cnt   = 16'(mcnt[id]);
    o.flag  = mflag[id];
    o.stall = mstall[id];
    return o;
  endfunction

  // Reference: pop frees a slot first, then valid lanes fill in order while room remains.
  task automatic model_step(int id, el2_trace_pkt_t [3:0] ln, bit en, bit rdy, bit clr);
    int unsigned dropped;
    int unsigned total;
    dropped = 0;
    if (rdy && mq[id].size() != 0) void'(mq[id].pop_front());
    for (int i = 0; i < NCHS[id]; i++) begin
      if (en && ln[i].trace_rv_i_valid_ip) begin
        if (mq[id].size() < DEP[id]) mq[id].push_back(ln[i]);
        else dropped++;
      end
    end
    if (clr) begin mcnt[id] = 0; mflag[id] = 1'b0; end
    total    = mcnt[id] + dropped;
    mcnt[id] = (total > CMX[id]) ? CMX[id] : total;
    if (dropped != 0) mflag[id] = 1'b1;
    mstall[id] = (STM[id] != 0) && ((DEP[id] - mq[id].size()) < NCHS[id]);
  endtask

  task automatic drive_idle();
    en_a = 0; en_b = 0; en_c = 0;
    clr_a = 0; clr_b = 0; clr_c = 0;
    if_a.trace_in_pkt = '0; if_b.trace_in_pkt = '0; if_c.trace_in_pkt = '0;
    if_a.trace_out_ready = 0; if_b.trace_out_ready = 0; if_c.trace_out_ready = 0;
  endtask

  task automatic cycle(int id, el2_trace_pkt_t [3:0] ln, bit en, bit rdy, bit clr);
    drive_idle();
    case (id)
      0: begin if_a.trace_in_pkt = ln[1:0]; en_a = en; if_a.trace_out_ready = rdy; clr_a = clr; end
      1: begin if_b.trace_in_pkt = ln;      en_b = en; if_b.trace_out_ready = rdy; clr_b = clr; end
      default: begin if_c.trace_in_pkt = ln[1:0]; en_c = en; if_c.trace_out_ready = rdy; clr_c = clr; end
    endcase
    model_step(id, ln, en, rdy, clr);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      mq[i].delete(); mcnt[i] = 0; mflag[i] = 0; mstall[i] = 0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int id = 0; id < 3; id++) begin
      n_cmp++;
      if (obs_of(id) !== obs_t'('0)) begin
        n_bad++; $display("FAIL reset_state[%0d]: got %h want 0", id, obs_of(id));
      end
    end
    for (int k = 0; k < 5; k++) begin
      drive_idle(); @(posedge clk); #1;
    end
    for (int id = 0; id < 3; id++) begin
      n_cmp++;
      if (obs_of(id) !== exp_obs(id)) begin
        n_bad++; $display("FAIL reset_idle[%0d]: got %h want %h", id, obs_of(id), exp_obs(id));
      end
    end
  endtask

  task automatic fill_a();
    el2_trace_pkt_t [3:0] ln;
    for (int k = 0; k < 4; k++) begin
      ln = '0;
      ln[0] = mk(1, 32'h100 + 32'(8 * k));
      ln[1] = mk(1, 32'h104 + 32'(8 * k));
      cycle(0, ln, 1, 0, 0);
      n_cmp++;
      if (obs_of(0) !== exp_obs(0)) begin
        n_bad++; $display("FAIL fill[%0d]: got %h want %h", k, obs_of(0), exp_obs(0));
      end
    end
  endtask

  task automatic test_burst();
    el2_trace_pkt_t [3:0] ln;
    do_reset();
    fill_a();
    n_cmp++;
    if (lvl_a !== 4'd8 || cnt_a !== 16'd0) begin
      n_bad++; $display("FAIL burst_full: got level %0d drops %0d want 8/0", lvl_a, cnt_a);
    end
    ln = '0; ln[0] = mk(1, 32'h120); ln[1] = mk(1, 32'h124);
    cycle(0, ln, 1, 0, 0);
    n_cmp++;
    if (cnt_a !== 16'd2 || flag_a !== 1'b1 || lvl_a !== 4'd8) begin
      n_bad++; $display("FAIL burst_drop: got cnt %0d flag %0d level %0d want 2/1/8", cnt_a, flag_a, lvl_a);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (if_a.trace_out_pkt.trace_rv_i_address_ip !== 32'h100 + 32'(4 * k)) begin
        n_bad++; $display("FAIL burst_order[%0d]: got %h want %h", k,
                          if_a.trace_out_pkt.trace_rv_i_address_ip, 32'h100 + 32'(4 * k));
      end
      cycle(0, '0, 0, 1, 0);
      n_cmp++;
      if (obs_of(0) !== exp_obs(0)) begin
        n_bad++; $display("FAIL burst_drain[%0d]: got %h want %h", k, obs_of(0), exp_obs(0));
      end
    end
  endtask

  task automatic test_sparse();
    el2_trace_pkt_t [3:0] ln;
    do_reset();
    ln[0] = mk(0, 32'hDEAD); ln[1] = mk(1, 32'hA0);
    ln[2] = mk(0, 32'hBEEF); ln[3] = mk(1, 32'hB0);
    cycle(1, ln, 1, 0, 0);
    n_cmp++;
    if (lvl_b !== 4'd2 || if_b.trace_out_pkt !== ln[1]) begin
      n_bad++; $display("FAIL sparse_first: got level %0d head %h want 2 %h", lvl_b, if_b.trace_out_pkt, ln[1]);
    end
    cycle(1, '0, 0, 1, 0);
    n_cmp++;
    if (lvl_b !== 4'd1 || if_b.trace_out_pkt !== ln[3]) begin
      n_bad++; $display("FAIL sparse_second: got level %0d head %h want 1 %h", lvl_b, if_b.trace_out_pkt, ln[3]);
    end
    n_cmp++;
    if (obs_of(1) !== exp_obs(1)) begin
      n_bad++; $display("FAIL sparse_model: got %h want %h", obs_of(1), exp_obs(1));
    end
  endtask

  task automatic test_full_pop();
    el2_trace_pkt_t [3:0] ln;
    logic [31:0] want;
    do_reset();
    fill_a();
    ln = '0; ln[0] = mk(1, 32'h200); ln[1] = mk(1, 32'h204);
    cycle(0, ln, 1, 1, 0);
    n_cmp++;
    if (lvl_a !== 4'd8 || cnt_a !== 16'd1 || flag_a !== 1'b1) begin
      n_bad++; $display("FAIL fullpop_count: got level %0d cnt %0d flag %0d want 8/1/1", lvl_a, cnt_a, flag_a);
    end
    for (int k = 0; k < 8; k++) begin
      want = (k == 7) ? 32'h200 : 32'h104 + 32'(4 * k);
      n_cmp++;
      if (if_a.trace_out_pkt.trace_rv_i_address_ip !== want) begin
        n_bad++; $display("FAIL fullpop_order[%0d]: got %h want %h", k,
                          if_a.trace_out_pkt.trace_rv_i_address_ip, want);
      end
      cycle(0, '0, 0, 1, 0);
    end
  endtask

  task automatic test_stall();
    el2_trace_pkt_t [3:0] ln;
    do_reset();
    ln = '0; ln[0] = mk(1, 32'h10); ln[1] = mk(1, 32'h14);
    cycle(2, ln, 1, 0, 0);
    n_cmp++;
    if (lvl_c !== 3'd2 || if_c.trace_stall !== 1'b0) begin
      n_bad++; $display("FAIL stall_lvl2: got level %0d stall %0d want 2/0", lvl_c, if_c.trace_stall);
    end
    ln = '0; ln[0] = mk(1, 32'h18);
    cycle(2, ln, 1, 0, 0);
    n_cmp++;
    if (lvl_c !== 3'd3 || if_c.trace_stall !== 1'b1) begin
      n_bad++; $display("FAIL stall_lvl3: got level %0d stall %0d want 3/1", lvl_c, if_c.trace_stall);
    end
    cycle(2, '0, 0, 1, 0);
    n_cmp++;
    if (lvl_c !== 3'd2 || if_c.trace_stall !== 1'b0) begin
      n_bad++; $display("FAIL stall_release: got level %0d stall %0d want 2/0", lvl_c, if_c.trace_stall);
    end
    n_cmp++;
    if (obs_of(2) !== exp_obs(2)) begin
      n_bad++; $display("FAIL stall_model: got %h want %h", obs_of(2), exp_obs(2));
    end
  endtask

  task automatic test_saturate();
    el2_trace_pkt_t [3:0] ln;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 4; i++) ln[i] = mk(1, 32'h300 + 32'(16 * k + 4 * i));
      cycle(1, ln, 1, 0, 0);
    end
    n_cmp++;
    if (cnt_b !== 4'd15 || flag_b !== 1'b1) begin
      n_bad++; $display("FAIL sat_cnt: got cnt %0d flag %0d want 15/1", cnt_b, flag_b);
    end
    ln = '0; ln[0] = mk(1, 32'h400);
    cycle(1, ln, 1, 0, 1);
    n_cmp++;
    if (cnt_b !== 4'd1 || flag_b !== 1'b1) begin
      n_bad++; $display("FAIL clr_with_drop: got cnt %0d flag %0d want 1/1", cnt_b, flag_b);
    end
    cycle(1, '0, 1, 0, 1);
    n_cmp++;
    if (cnt_b !== 4'd0 || flag_b !== 1'b0) begin
      n_bad++; $display("FAIL clr_plain: got cnt %0d flag %0d want 0/0", cnt_b, flag_b);
    end
  endtask

  task automatic test_random();
    el2_trace_pkt_t [3:0] ln;
    bit en, rdy, clr;
    for (int id = 0; id < 3; id++) begin
      do_reset();
      for (int k = 0; k < 300; k++) begin
        for (int i = 0; i < 4; i++) ln[i] = mk(1'($urandom_range(0, 1)), $urandom);
        if (STM[id] != 0 && mstall[id] && $urandom_range(0, 3) != 0) begin
          for (int i = 0; i < 4; i++) ln[i].trace_rv_i_valid_ip = 1'b0;
        end
        en  = ($urandom_range(0, 9) != 0);
        rdy = ($urandom_range(0, 1) != 0);
        clr = ($urandom_range(0, 19) == 0);
        cycle(id, ln, en, rdy, clr);
        n_cmp++;
        if (obs_of(id) !== exp_obs(id)) begin
          n_bad++; $display("FAIL random[%0d.%0d]: got %h want %h", id, k, obs_of(id), exp_obs(id));
        end
      end
      do_reset();
      n_cmp++;
      if (obs_of(id) !== obs_t'('0)) begin
        n_bad++; $display("FAIL midrun_reset[%0d]: got %h want 0", id, obs_of(id));
      end
    end
  endtask

  initial begin
    rst = 1;
    drive_idle();
    @(posedge clk); #1;
    test_reset();
    test_burst();
    test_sparse();
    test_full_pop();
    test_stall();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/el2_trace_buf.md
Name: el2_trace_buf

Overview:
- Parametrised multi-lane retire-trace buffer.
- Accepts up to NCH el2_trace_pkt_t packets per cycle from the retire lanes of the decode/TLU trace port.
- Compacts the accepted packets into a DEPTH-entry circular FIFO and drains them one per cycle to a valid/ready trace sink (debug/trace encoder).
- Supports drop-on-full or stall-upstream overflow modes, with a saturating drop counter and a sticky drop flag.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2, >= NCH.
- NCH, 2, input retire lanes per cycle; 1..4.
- OVF_MODE, 0, 0 = drop packets that do not fit; 1 = assert trace_stall to hold upstream.
- CNT_W, 16, drop counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- trace_en  in  1  capture enable; when low, inputs are ignored and not counted as drops.
- trace_in_pkt  in  NCH x el2_trace_pkt_t  lane packets; lane i is valid iff trace_rv_i_valid_ip=1.
- trace_stall  out  1  OVF_MODE=1 only: upstream must not present valid packets this cycle.
- trace_out_valid  out  1  head entry is valid.
- trace_out_pkt  out  el2_trace_pkt_t  head packet.
- trace_out_ready  in  1  sink accepts the head entry.
- level  out  $clog2(DEPTH+1)  current occupancy.
- drop_cnt  out  CNT_W  saturating count of dropped packets.
- drop_flag  out  1  sticky; set on any drop.
- drop_clr  in  1  clears drop_cnt and drop_flag.

Behaviour:
- Reset:
  - wr_ptr=rd_ptr=0, level=0.
  - trace_out_valid=0, trace_out_pkt=0.
  - drop_cnt=0, drop_flag=0, trace_stall=0.
  - Entry storage is not reset.
- Reset mid-operation empties the FIFO in one cycle; buffered packets are discarded and not counted.
- Pop: pop = trace_out_valid & trace_out_ready.
  - trace_out_valid = (level != 0).
  - trace_out_pkt = mem[rd_ptr].
  - rd_ptr advances by 1 mod DEPTH.
- Push:
  - Valid lanes are enqueued in ascending lane order, compacted with no gaps.
  - Example: lanes {0,2} valid are written to wr_ptr and wr_ptr+1.
  - A packet pushed in cycle N appears on trace_out no earlier than cycle N+1. Write-to-read bypass is not allowed.
- Space:
  - avail = DEPTH - level + pop.
  - A same-cycle pop frees one slot for the pushes in that cycle.
  - accepted = min(nvalid, avail); the first `accepted` valid lanes in lane order are written.
  - dropped = nvalid - accepted.
  - wr_ptr += accepted mod DEPTH.
  - level_next = level + accepted - pop.
  - Pointers wrap naturally at DEPTH. Full is distinguished from empty by level, not by pointer equality.
- OVF_MODE=1:
  - trace_stall = (DEPTH - level) < NCH, registered: computed from level_next and flopped.
  - Packets presented while trace_stall=1 are a protocol violation. They are still processed by the avail rule (fit or drop, counted) and are never silently lost.
- OVF_MODE=0: trace_stall is tied to 0.
- Drop accounting:
  - drop_cnt_next = sat(drop_cnt + dropped), where sat clamps at 2^CNT_W-1.
  - drop_flag set when dropped>0.
  - When drop_clr and a drop occur in the same cycle: drop_cnt = dropped of that cycle and drop_flag = (dropped>0).
- trace_en=0:
  - nvalid is forced to 0.
  - Draining continues.
  - Counters hold unless drop_clr is asserted.
- Packet contents (exception, ecause, interrupt, tval) are stored unmodified. No field is interpreted except trace_rv_i_valid_ip.

Decomposition:
- el2_pkg: reuse el2_trace_pkt_t.
- el2_pkg additions:
  - el2_trace_ovf_mode_t enum (TRC_DROP=1'b0, TRC_STALL=1'b1), used for OVF_MODE.
  - Localparam TRACE_PKT_W = $bits(el2_trace_pkt_t).
- One sub-module: el2_trace_lane_pack.
  - Combinational per-lane valid compaction and prefix-count.
  - Outputs a write-slot offset per lane and nvalid.
  - Parametrised by NCH.
- Storage and pointers stay in el2_trace_buf.

Test Plan:
- Reset then idle: after rst, level=0, trace_out_valid=0, drop_cnt=0, trace_stall=0; after 5 idle cycles, all unchanged.
- Two-lane burst, NCH=2, DEPTH=8, OVF_MODE=0, ready=0: 4 cycles with both lanes valid (addr 0x100..0x11C) -> level=8, no drops. The 5th cycle's pair gives drop_cnt=2, drop_flag=1. Then with ready=1 the drain order is 0x100, 0x104, …, 0x11C.
- Sparse lanes, NCH=4: lanes {1,3} valid with addr 0xA0 and 0xB0 -> FIFO entries 0xA0 then 0xB0. level=2 the next cycle.
- Full with simultaneous pop: level=8, ready=1, 2 lanes valid -> one packet accepted, one dropped. level stays 8, drop_cnt += 1. The lane 0 packet is the one kept.
- Stall mode, OVF_MODE=1, NCH=2, DEPTH=4: after pushes reach level=3, trace_stall=1 the next cycle. After one pop, level=2 and trace_stall=0 the following cycle.
- Counter saturation and clear, CNT_W=4: force 20 drops -> drop_cnt=15. drop_clr together with a 1-packet drop in the same cycle -> drop_cnt=1, drop_flag=1.
